control_unit_param: RTL and testbench

//  Parametrised multicycle control unit for the switch-driven CPU. Sequences
//  OFF/INIT/FETCH/DECODE/EXECUTE/WRITEBACK and drives the register bank and ALU.

---
 rtl/control_unit_param_pkg.sv | 26 ++
 rtl/control_unit_param_key_press_det.sv | 21 ++
 rtl/control_unit_param.sv | 231 +++++++++++++++++++++++
 tb/tb_control_unit_param.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_param_pkg.sv
// Shared opcodes, FSM state encoding and LCD constants for the control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cu_pkg;

  // Instruction opcodes (top 3 bits of the instruction word)
  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  // LCD controller command that clears the display
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_INIT      = 3'd1,
    ST_FETCH     = 3'd2,
    ST_DECODE    = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_LCD_REQ   = 3'd6
  } cu_state_t;

endpackage

// File: rtl/control_unit_param_key_press_det.sv
// Falling-edge detector for an active-low, already synchronised key.
// Latency: press is high in the cycle the key is first seen low (history is registered).
// Backpressure: none; a held key yields exactly one press until released.
module key_press_det (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic prev_q;

  // Key history; released (1) after reset so a key held through reset is not a press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_q <= 1'b1;
    else        prev_q <= key;
  end

  assign press = prev_q & ~key;

endmodule

// File: rtl/control_unit_param.sv
// Multicycle control unit: OFF/INIT/FETCH/DECODE/EXECUTE/WRITEBACK/LCD_REQ sequencer.
// Latency: LOAD 2 cycles, ALU ops 3 cycles from the latch; LCD ops wait for lcd_ack.
// Backpressure: lcd_req held until lcd_ack; keys outside OFF/FETCH are dropped. Option: CU_INSTR_COUNT_EN.
module control_unit_param
  import cu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int IMM_W      = 6,
  parameter int INIT_CYC   = 50000,
  localparam int INSTR_W   = 3 + 2*REG_ADDR_W + 1 + IMM_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_ligar,
  input  logic                  key_enviar,
  input  logic [INSTR_W-1:0]    instruction_input,
  input  logic [DATA_W-1:0]     reg_data_out_a,
  input  logic [DATA_W-1:0]     reg_data_out_b,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  lcd_ack,
  output logic                  led_off,
  output logic                  led_ready,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] reg_dest,
  output logic [REG_ADDR_W-1:0] reg_src1,
  output logic [REG_ADDR_W-1:0] reg_src2,
  output logic [DATA_W-1:0]     reg_data_in,
  output logic [2:0]            alu_op,
  output logic [DATA_W-1:0]     alu_op_a,
  output logic [DATA_W-1:0]     alu_op_b,
  output logic                  lcd_req,
  output logic                  lcd_rs,
  output logic [7:0]            lcd_data,
`ifdef CU_INSTR_COUNT_EN
  output logic [15:0]           retired_cnt,
`endif
  output logic                  busy
);

  localparam int CNT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYC - 1);

  cu_state_t           state_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [CNT_W-1:0]    init_cnt;
  logic                ligar_press;
  logic                enviar_press;

  // Field views of the latched instruction and of the live switches
  logic [2:0]            opc_q;
  logic [REG_ADDR_W-1:0] dest_q, dest_in, src1_in, src2_in;
  logic [DATA_W-1:0]     imm_sext;

  assign opc_q    = instr_q[INSTR_W-1 -: 3];
  assign dest_q   = instr_q[INSTR_W-4 -: REG_ADDR_W];
  assign dest_in  = instruction_input[INSTR_W-4 -: REG_ADDR_W];
  assign src1_in  = instruction_input[INSTR_W-4-REG_ADDR_W -: REG_ADDR_W];
  assign src2_in  = instruction_input[REG_ADDR_W-1:0];
  assign imm_sext = {{(DATA_W-IMM_W-1){instr_q[IMM_W]}}, instr_q[IMM_W:0]};

  key_press_det u_ligar (
    .clk   (clk),
    .reset (reset),
    .key   (key_ligar),
    .press (ligar_press)
  );

  key_press_det u_enviar (
    .clk   (clk),
    .reset (reset),
    .key   (key_enviar),
    .press (enviar_press)
  );

  // Sequencer; every output is registered and set on entry to the state that owns it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_OFF;
      instr_q     <= '0;
      init_cnt    <= '0;
      led_off     <= 1'b1;
      led_ready   <= 1'b0;
      busy        <= 1'b0;
      reg_write   <= 1'b0;
      reg_dest    <= '0;
      reg_src1    <= '0;
      reg_src2    <= '0;
      reg_data_in <= '0;
      alu_op      <= '0;
      alu_op_a    <= '0;
      alu_op_b    <= '0;
      lcd_req     <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_data    <= '0;
    end else begin
      reg_write <= 1'b0;
      case (state_q)
        ST_OFF: begin
          if (ligar_press) begin
            state_q  <= ST_INIT;
            init_cnt <= '0;
            led_off  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state_q   <= ST_FETCH;
            busy      <= 1'b0;
            led_ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt + CNT_W'(1);
          end
        end
        ST_FETCH: begin
          // Power key wins over a simultaneous submit
          if (ligar_press) begin
            state_q   <= ST_OFF;
            led_ready <= 1'b0;
            led_off   <= 1'b1;
          end else if (enviar_press) begin
            state_q   <= ST_DECODE;
            instr_q   <= instruction_input;
            reg_dest  <= dest_in;
            reg_src1  <= src1_in;
            reg_src2  <= src2_in;
            led_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_DECODE: begin
          case (opc_q)
            OP_LOAD: begin
              state_q     <= ST_WRITEBACK;
              reg_write   <= 1'b1;
              reg_data_in <= imm_sext;
            end
            OP_CLEAR: begin
              state_q  <= ST_LCD_REQ;
              lcd_req  <= 1'b1;
              lcd_rs   <= 1'b0;
              lcd_data <= LCD_CMD_CLEAR;
            end
            OP_DISPLAY: begin
              // src1 is already on the read port, so its low byte is captured here
              state_q  <= ST_LCD_REQ;
              lcd_req  <= 1'b1;
              lcd_rs   <= 1'b1;
              lcd_data <= reg_data_out_a[7:0];
            end
            default: begin
              state_q  <= ST_EXECUTE;
              alu_op   <= opc_q;
              alu_op_a <= reg_data_out_a;
              alu_op_b <= (opc_q == OP_ADD || opc_q == OP_SUB) ? reg_data_out_b : imm_sext;
            end
          endcase
        end
        ST_EXECUTE: begin
          state_q     <= ST_WRITEBACK;
          reg_write   <= 1'b1;
          reg_data_in <= alu_result;
          reg_dest    <= dest_q;
          alu_op      <= '0;
          alu_op_a    <= '0;
          alu_op_b    <= '0;
        end
        ST_WRITEBACK: begin
          state_q     <= ST_FETCH;
          reg_data_in <= '0;
          reg_dest    <= '0;
          reg_src1    <= '0;
          reg_src2    <= '0;
          busy        <= 1'b0;
          led_ready   <= 1'b1;
        end
        ST_LCD_REQ: begin
          if (lcd_ack) begin
            state_q   <= ST_FETCH;
            lcd_req   <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= '0;
            reg_dest  <= '0;
            reg_src1  <= '0;
            reg_src2  <= '0;
            busy      <= 1'b0;
            led_ready <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_OFF;
          led_off     <= 1'b1;
          led_ready   <= 1'b0;
          busy        <= 1'b0;
          reg_dest    <= '0;
          reg_src1    <= '0;
          reg_src2    <= '0;
          reg_data_in <= '0;
          alu_op      <= '0;
          alu_op_a    <= '0;
          alu_op_b    <= '0;
          lcd_req     <= 1'b0;
          lcd_rs      <= 1'b0;
          lcd_data    <= '0;
        end
      endcase
    end
  end

`ifdef CU_INSTR_COUNT_EN
  logic [15:0] retired_q;
  logic        retire;
  logic        enter_off;

  assign retire    = (state_q == ST_WRITEBACK) || (state_q == ST_LCD_REQ && lcd_ack);
  assign enter_off = (state_q == ST_FETCH && ligar_press) ||
                     !(state_q inside {ST_OFF, ST_INIT, ST_FETCH, ST_DECODE,
                                       ST_EXECUTE, ST_WRITEBACK, ST_LCD_REQ});

  // Retired-instruction count; wraps naturally, restarts whenever the unit powers off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         retired_q <= '0;
    else if (enter_off) retired_q <= '0;
    else if (retire)    retired_q <= retired_q + 16'd1;
  end

  assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_control_unit_param.sv
module tb_control_unit_param;

  localparam int INIT_CYC = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_ligar = 1'b1;
  logic        key_enviar = 1'b1;
  logic        lcd_ack = 1'b0;
  logic [17:0] instruction_input = '0;
  logic [15:0] reg_data_out_a, reg_data_out_b, alu_result;
  logic        led_off, led_ready, reg_write, lcd_req, lcd_rs, busy;
  logic [3:0]  reg_dest, reg_src1, reg_src2;
  logic [15:0] reg_data_in, alu_op_a, alu_op_b;
  logic [2:0]  alu_op;
  logic [7:0]  lcd_data;
`ifdef CU_INSTR_COUNT_EN
  logic [15:0] retired_cnt;
`endif

  int checks = 0;
  int passes = 0;
  logic [19:0] sb[$];

  logic [15:0] regs [16] = '{default: 16'h0000};
  logic        preload_en = 1'b0;
  logic [3:0]  preload_idx = '0;
  logic [15:0] preload_val = '0;

  always #5 clk = ~clk;

  control_unit_param #(.INIT_CYC(INIT_CYC)) dut (
    .clk(clk), .reset(reset), .key_ligar(key_ligar), .key_enviar(key_enviar),
    .instruction_input(instruction_input), .reg_data_out_a(reg_data_out_a),
    .reg_data_out_b(reg_data_out_b), .alu_result(alu_result), .lcd_ack(lcd_ack),
    .led_off(led_off), .led_ready(led_ready), .reg_write(reg_write),
    .reg_dest(reg_dest), .reg_src1(reg_src1), .reg_src2(reg_src2),
    .reg_data_in(reg_data_in), .alu_op(alu_op), .alu_op_a(alu_op_a),
    .alu_op_b(alu_op_b), .lcd_req(lcd_req), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
`ifdef CU_INSTR_COUNT_EN
    .retired_cnt(retired_cnt),
`endif
    .busy(busy)
  );

  // Register bank model
  always @(posedge clk) begin
    if (preload_en)                 regs[preload_idx] <= preload_val;
    else if (reset && reg_write)    regs[reg_dest] <= reg_data_in;
  end
  assign reg_data_out_a = regs[reg_src1];
  assign reg_data_out_b = regs[reg_src2];

  // ALU model
  always_comb begin
    alu_result = alu_op_a;
    case (alu_op)
      3'b001, 3'b010: alu_result = alu_op_a + alu_op_b;
      3'b011:         alu_result = alu_op_a - alu_op_b;
      3'b100:         alu_result = alu_op_a & alu_op_b;
      3'b101:         alu_result = alu_op_a | alu_op_b;
      default:        alu_result = alu_op_a;
    endcase
  end

  // Scoreboard: every register write must match the oldest expected write
  always @(negedge clk) begin
    if (reset === 1'b1 && reg_write === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL wb_unexpected: got dest=%0d data=%h, expected no write", reg_dest, reg_data_in);
      end else begin
        logic [19:0] exp_w;
        exp_w = sb.pop_front();
        if ({reg_dest, reg_data_in} !== exp_w)
          $display("FAIL wb_data: got dest=%0d data=%h, expected dest=%0d data=%h",
                   reg_dest, reg_data_in, exp_w[19:16], exp_w[15:0]);
        else passes++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [17:0] mk_ri(input logic [2:0] op, input logic [3:0] d,
                                        input logic [3:0] s1, input logic [6:0] imm);
    return {op, d, s1, imm};
  endfunction

  function automatic logic [17:0] mk_rr(input logic [2:0] op, input logic [3:0] d,
                                        input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, 3'b000, s2};
  endfunction

  // Called at posedge+1; key is seen low at the next posedge, then released
  task automatic press(input bit lig, input bit env);
    if (lig) key_ligar = 1'b0;
    if (env) key_enviar = 1'b0;
    @(posedge clk); #1;
    key_ligar = 1'b1;
    key_enviar = 1'b1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [15:0] val);
    preload_en = 1'b1; preload_idx = idx; preload_val = val;
    @(posedge clk); #1;
    preload_en = 1'b0;
  endtask

  // Waits for FETCH, acknowledging any LCD request; returns cycles spent not ready
  task automatic wait_fetch(input string tag, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (led_ready === 1'b1) break;
      if (lcd_req === 1'b1) lcd_ack = 1'b1;
      n++;
      if (n > 100) break;
      @(posedge clk); #1;
      lcd_ack = 1'b0;
    end
    checks++;
    if (n > 100) $display("FAIL %s_timeout: no FETCH after %0d cycles, expected within 100", tag, n);
    else passes++;
    lcd_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input string tag, input logic [17:0] ins);
    int n;
    instruction_input = ins;
    press(1'b0, 1'b1);
    wait_fetch(tag, n);
  endtask

  task automatic power_up(input string tag);
    int n;
    press(1'b1, 1'b0);
    wait_fetch(tag, n);
  endtask

  task automatic test_reset;
    int n, bad;
    #2;
    @(negedge clk);
    checks++;
    if (led_off !== 1'b1) $display("FAIL reset_led_off: got %b, expected 1", led_off);
    else passes++;
    checks++;
    if ({led_ready, busy, reg_write, lcd_req, lcd_rs, lcd_data, alu_op, reg_data_in, alu_op_a} !== '0)
      $display("FAIL reset_outputs: got ready=%b busy=%b wr=%b req=%b, expected all 0",
               led_ready, busy, reg_write, lcd_req);
    else passes++;
    @(posedge clk); #1;
    reset = 1'b1;
    press(1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || led_off !== 1'b0)
      $display("FAIL init_entry: got busy=%b led_off=%b, expected 1/0", busy, led_off);
    else passes++;
    @(posedge clk); #1;
    // Submit during INIT must be discarded
    press(1'b0, 1'b1);
    wait_fetch("init", n);
    checks++;
    if (n != INIT_CYC - 2) $display("FAIL init_dwell: got %0d, expected %0d", n, INIT_CYC - 2);
    else passes++;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || led_ready !== 1'b1 || reg_write !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) $display("FAIL init_key_discard: got %0d non-idle cycles, expected 0", bad);
    else passes++;
  endtask

  task automatic test_load;
    int n_wr;
    instruction_input = mk_ri(3'b000, 4'd3, 4'd0, 7'b1111011);
    sb.push_back({4'd3, 16'hFFFB});
    press(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || led_ready !== 1'b0)
      $display("FAIL load_decode: got busy=%b ready=%b, expected 1/0", busy, led_ready);
    else passes++;
    n_wr = 0;
    for (int i = 0; i < 10; i++) begin
      if (reg_write === 1'b1) n_wr++;
      if (led_ready === 1'b1) break;
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    checks++;
    if (n_wr != 1) $display("FAIL load_write_pulse: got %0d cycles, expected 1", n_wr);
    else passes++;
    checks++;
    if (sb.size() != 0) $display("FAIL load_pending: got %0d pending writes, expected 0", sb.size());
    else passes++;
  endtask

  task automatic test_alu;
    int n;
    sb.push_back({4'd1, 16'd7});
    run_instr("ld_r1", mk_ri(3'b000, 4'd1, 4'd0, 7'd7));
    sb.push_back({4'd2, 16'd9});
    run_instr("ld_r2", mk_ri(3'b000, 4'd2, 4'd0, 7'd9));
    // ADD r4,r1,r2 with switches scrambled right after the latch
    instruction_input = mk_rr(3'b001, 4'd4, 4'd1, 4'd2);
    sb.push_back({4'd4, 16'd16});
    press(1'b0, 1'b1);
    instruction_input = mk_ri(3'b000, 4'd5, 4'd9, 7'h7F);
    @(negedge clk);
    checks++;
    if (reg_src1 !== 4'd1 || reg_src2 !== 4'd2)
      $display("FAIL add_decode_src: got %0d,%0d, expected 1,2", reg_src1, reg_src2);
    else passes++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (alu_op !== 3'b001) $display("FAIL add_alu_op: got %b, expected 001", alu_op);
    else passes++;
    checks++;
    if (alu_op_a !== 16'd7 || alu_op_b !== 16'd9)
      $display("FAIL add_operands: got a=%h b=%h, expected 0007/0009", alu_op_a, alu_op_b);
    else passes++;
    @(posedge clk); #1;
    wait_fetch("add", n);
    // ADDI r6,r1,-2: operand b is the sign-extended immediate
    instruction_input = mk_ri(3'b010, 4'd6, 4'd1, 7'b1111110);
    sb.push_back({4'd6, 16'd5});
    press(1'b0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (alu_op !== 3'b010 || alu_op_b !== 16'hFFFE)
      $display("FAIL addi_operand: got op=%b b=%h, expected 010/FFFE", alu_op, alu_op_b);
    else passes++;
    @(posedge clk); #1;
    wait_fetch("addi", n);
    sb.push_back({4'd7, 16'hFFFE});
    run_instr("sub", mk_rr(3'b011, 4'd7, 4'd1, 4'd2));
    checks++;
    if (sb.size() != 0) $display("FAIL alu_pending: got %0d pending writes, expected 0", sb.size());
    else passes++;
  endtask

  task automatic test_lcd;
    int hi, bad, bad_stray;
    bit done;
    preload(4'd4, 16'h0141);
    // Stray ack while in FETCH is ignored
    lcd_ack = 1'b1;
    bad_stray = 0;
    repeat (2) begin
      @(negedge clk);
      if (led_ready !== 1'b1 || busy !== 1'b0 || lcd_req !== 1'b0) bad_stray++;
      @(posedge clk); #1;
    end
    lcd_ack = 1'b0;
    checks++;
    if (bad_stray != 0) $display("FAIL stray_ack: got %0d disturbed cycles, expected 0", bad_stray);
    else passes++;
    instruction_input = mk_ri(3'b111, 4'd0, 4'd4, 7'd0);
    press(1'b0, 1'b1);
    @(posedge clk); #1;
    // Register changes after entry must not reach lcd_data
    preload_en = 1'b1; preload_idx = 4'd4; preload_val = 16'h00AA;
    hi = 0; bad = 0; done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (led_ready === 1'b1) begin done = 1'b1; break; end
      if (lcd_req === 1'b1) hi++;
      if (lcd_req !== 1'b1 || lcd_rs !== 1'b1 || lcd_data !== 8'h41) bad++;
      if (hi == 20) lcd_ack = 1'b1;
      @(posedge clk); #1;
      preload_en = 1'b0;
      lcd_ack = 1'b0;
    end
    checks++;
    if (!done || hi != 20) $display("FAIL display_req_len: got %0d cycles, expected 20", hi);
    else passes++;
    checks++;
    if (bad != 0) $display("FAIL display_stable: got %0d bad cycles, expected 0 (rs=1 data=41)", bad);
    else passes++;
    checks++;
    if (lcd_req !== 1'b0) $display("FAIL display_release: got lcd_req=%b, expected 0", lcd_req);
    else passes++;
    @(posedge clk); #1;
    // CLEAR: command byte, immediate ack
    instruction_input = mk_ri(3'b110, 4'd0, 4'd0, 7'd0);
    press(1'b0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (lcd_req !== 1'b1 || lcd_rs !== 1'b0 || lcd_data !== 8'h01)
      $display("FAIL clear_req: got req=%b rs=%b data=%h, expected 1/0/01", lcd_req, lcd_rs, lcd_data);
    else passes++;
    lcd_ack = 1'b1;
    @(posedge clk); #1;
    lcd_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (led_ready !== 1'b1 || lcd_req !== 1'b0)
      $display("FAIL clear_done: got ready=%b req=%b, expected 1/0", led_ready, lcd_req);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_both_keys;
    int bad;
    instruction_input = mk_ri(3'b000, 4'd8, 4'd0, 7'd1);
    press(1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (led_off !== 1'b1 || led_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL both_keys_off: got off=%b ready=%b busy=%b, expected 1/0/0", led_off, led_ready, busy);
    else passes++;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (reg_write !== 1'b0 || led_off !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL both_keys_nodecode: got %0d bad cycles, expected 0", bad);
    else passes++;
    @(posedge clk); #1;
    power_up("both_keys");
  endtask

  task automatic test_reset_mid;
    instruction_input = mk_ri(3'b111, 4'd0, 4'd4, 7'd0);
    press(1'b0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (lcd_req !== 1'b1) $display("FAIL rst_pre_req: got %b, expected 1", lcd_req);
    else passes++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (led_off !== 1'b1 || lcd_req !== 1'b0 || reg_write !== 1'b0)
      $display("FAIL rst_mid_lcd: got off=%b req=%b wr=%b, expected 1/0/0", led_off, lcd_req, reg_write);
    else passes++;
    @(posedge clk); #1;
    reset = 1'b1;
    power_up("rst_lcd");
    // Reset landing in WRITEBACK suppresses the write
    instruction_input = mk_ri(3'b000, 4'd9, 4'd0, 7'd3);
    press(1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (reg_write !== 1'b0 || led_off !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_mid_wb: got wr=%b off=%b busy=%b, expected 0/1/0", reg_write, led_off, busy);
    else passes++;
    @(posedge clk); #1;
    reset = 1'b1;
    power_up("rst_wb");
  endtask

`ifdef CU_INSTR_COUNT_EN
  task automatic test_counter;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    power_up("cnt");
    sb.push_back({4'd1, 16'd3});
    run_instr("cnt_ld", mk_ri(3'b000, 4'd1, 4'd0, 7'd3));
    sb.push_back({4'd5, 16'd6});
    run_instr("cnt_add", mk_rr(3'b001, 4'd5, 4'd1, 4'd1));
    run_instr("cnt_clr", mk_ri(3'b110, 4'd0, 4'd0, 7'd0));
    @(negedge clk);
    checks++;
    if (retired_cnt !== 16'd3) $display("FAIL retired_three: got %h, expected 0003", retired_cnt);
    else passes++;
    @(posedge clk); #1;
    force dut.retired_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.retired_q;
    sb.push_back({4'd2, 16'd1});
    run_instr("cnt_wrap", mk_ri(3'b000, 4'd2, 4'd0, 7'd1));
    @(negedge clk);
    checks++;
    if (retired_cnt !== 16'h0000) $display("FAIL retired_wrap: got %h, expected 0000", retired_cnt);
    else passes++;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_alu();
    test_lcd();
    test_both_keys();
    test_reset_mid();
`ifdef CU_INSTR_COUNT_EN
    test_counter();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
